// File: rtl/dmem_dbg_arbiter_pkg.sv
// Shared encodings for the data-memory / debug-port arbiter.
// Holds the arbiter state type and the DMEM word-address width.
`timescale 1ns/1ps
package dmem_dbg_arbiter_pkg;

  localparam int DMEM_ADDR_W = 5;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_WAIT = 2'd1,
    ARB_ACK  = 2'd2
  } arb_state_t;

endpackage

// File: rtl/dmem_dbg_arbiter.sv
// Shares the single-port DMEM between the CPU MEM stage (priority) and a debug port.
// A pending debug request wins after MAX_WAIT busy cycles, stalling the CPU for one cycle.
`timescale 1ns/1ps
module dmem_dbg_arbiter
  import dmem_dbg_arbiter_pkg::*;
#(
  parameter int ADDR_W   = DMEM_ADDR_W,
  parameter int MAX_WAIT = 8,
  parameter int CNT_W    = 16
) (
  input  logic              CLK_CPU,
  input  logic              RST_CPU,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [31:0]       cpu_wdata,
  output logic [31:0]       cpu_rdata,
  output logic              cpu_stall,
  input  logic              dbg_req,
  input  logic              dbg_we,
  input  logic [ADDR_W-1:0] dbg_addr,
  input  logic [31:0]       dbg_wdata,
  output logic              dbg_ack,
  output logic [31:0]       dbg_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  output logic [CNT_W-1:0]  stall_cnt
);

  localparam int            WW       = (MAX_WAIT > 0) ? $clog2(MAX_WAIT + 1) : 1;
  localparam logic [WW-1:0] WAIT_MAX = WW'(MAX_WAIT);

  arb_state_t       r_state;
  arb_state_t       w_state_nxt;
  logic [WW-1:0]    r_wait_cnt;
  logic [WW-1:0]    w_wait_nxt;
  logic             r_dbg_ack;
  logic             w_ack_nxt;
  logic             w_rdata_ld;
  logic [31:0]      r_dbg_rdata;
  logic [CNT_W-1:0] r_stall_cnt;
  logic             w_dbg_win;

  // Debug owns memory only in a WAIT cycle where the request is still held.
  assign w_dbg_win = (r_state == ARB_WAIT) && dbg_req &&
                     (!cpu_req || (r_wait_cnt == WAIT_MAX));

  assign cpu_stall = w_dbg_win && cpu_req;
  assign cpu_rdata = mem_rdata;
  assign dbg_ack   = r_dbg_ack;
  assign dbg_rdata = r_dbg_rdata;
  assign stall_cnt = r_stall_cnt;

  always_comb begin
    mem_en    = cpu_req;
    mem_we    = cpu_req && cpu_we;
    mem_addr  = cpu_addr;
    mem_wdata = cpu_wdata;
    if (w_dbg_win) begin
      mem_en    = 1'b1;
      mem_we    = dbg_we;
      mem_addr  = dbg_addr;
      mem_wdata = dbg_wdata;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_wait_nxt  = r_wait_cnt;
    w_ack_nxt   = r_dbg_ack;
    w_rdata_ld  = 1'b0;
    case (r_state)
      ARB_IDLE: begin
        if (dbg_req) begin
          w_state_nxt = ARB_WAIT;
          w_wait_nxt  = '0;
        end
      end
      ARB_WAIT: begin
        if (!dbg_req) begin
          w_state_nxt = ARB_IDLE;
        end else if (w_dbg_win) begin
          w_state_nxt = ARB_ACK;
          w_ack_nxt   = 1'b1;
          w_rdata_ld  = 1'b1;
        end else begin
          w_wait_nxt = r_wait_cnt + WW'(1);
        end
      end
      ARB_ACK: begin
        if (!dbg_req) begin
          w_state_nxt = ARB_IDLE;
          w_ack_nxt   = 1'b0;
        end
      end
      default: w_state_nxt = ARB_IDLE;
    endcase
  end

  always_ff @(posedge CLK_CPU or posedge RST_CPU) begin
    if (RST_CPU) begin
      r_state    <= ARB_IDLE;
      r_wait_cnt <= '0;
      r_dbg_ack  <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_wait_cnt <= w_wait_nxt;
      r_dbg_ack  <= w_ack_nxt;
    end
  end

  // Captured before the write lands, so a debug write returns the old word.
  always_ff @(posedge CLK_CPU or posedge RST_CPU) begin
    if (RST_CPU) begin
      r_dbg_rdata <= '0;
    end else if (w_rdata_ld) begin
      r_dbg_rdata <= mem_rdata;
    end
  end

  always_ff @(posedge CLK_CPU or posedge RST_CPU) begin
    if (RST_CPU) begin
      r_stall_cnt <= '0;
    end else if (cpu_stall && (r_stall_cnt != {CNT_W{1'b1}})) begin
      r_stall_cnt <= r_stall_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_dmem_dbg_arbiter.sv
// Directed bench for dmem_dbg_arbiter: behavioural DMEM, scoreboard on debug read data.
`timescale 1ns/1ps
module tb_dmem_dbg_arbiter;

  logic        clk;
  logic        rst;
  logic        cpu_req, cpu_we, dbg_req, dbg_we;
  logic [4:0]  cpu_addr, dbg_addr;
  logic [31:0] cpu_wdata, dbg_wdata;
  logic [31:0] cpu_rdata, dbg_rdata, mem_wdata, mem_rdata;
  logic        cpu_stall, dbg_ack, mem_en, mem_we;
  logic [4:0]  mem_addr;
  logic [15:0] stall_cnt;

  // Second instance: tiny saturating counter and zero tolerated wait.
  logic        s_cpu_req, s_dbg_req, s_stall, s_ack, s_mem_en, s_mem_we;
  logic [31:0] s_cpu_rdata, s_dbg_rdata, s_mem_wdata;
  logic [4:0]  s_mem_addr;
  logic [1:0]  s_stall_cnt;

  logic [31:0] mem [0:31];
  logic [31:0] exp_q[$];
  int          n_tests = 0;
  int          n_fail  = 0;
  int          dbg_acc = 0;
  int          cpu_acc = 0;
  int          stall_cyc = 0;
  logic [4:0]  last_stall_addr = '0;
  logic        ack_prev = 1'b0;

  dmem_dbg_arbiter #(.ADDR_W(5), .MAX_WAIT(8), .CNT_W(16)) dut (
    .CLK_CPU(clk), .RST_CPU(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
    .dbg_ack(dbg_ack), .dbg_rdata(dbg_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .stall_cnt(stall_cnt)
  );

  dmem_dbg_arbiter #(.ADDR_W(5), .MAX_WAIT(0), .CNT_W(2)) u_sat (
    .CLK_CPU(clk), .RST_CPU(rst),
    .cpu_req(s_cpu_req), .cpu_we(1'b0), .cpu_addr(5'd1), .cpu_wdata(32'h0),
    .cpu_rdata(s_cpu_rdata), .cpu_stall(s_stall),
    .dbg_req(s_dbg_req), .dbg_we(1'b0), .dbg_addr(5'd2), .dbg_wdata(32'h0),
    .dbg_ack(s_ack), .dbg_rdata(s_dbg_rdata),
    .mem_en(s_mem_en), .mem_we(s_mem_we), .mem_addr(s_mem_addr), .mem_wdata(s_mem_wdata),
    .mem_rdata(32'h0), .stall_cnt(s_stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign mem_rdata = mem[mem_addr];
  always @(posedge clk) begin
    if (mem_en && mem_we) mem[mem_addr] <= mem_wdata;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_ack(input int lim, output int n);
    n = 0;
    while (!dbg_ack && n < lim) begin
      tick(1);
      n++;
    end
  endtask

  task automatic cpu_write(input logic [4:0] a, input logic [31:0] d);
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = a; cpu_wdata = d;
    tick(1);
    cpu_req = 1'b0; cpu_we = 1'b0;
  endtask

  // Monitor: scoreboard on each ack rising edge, plus access bookkeeping.
  always @(negedge clk) begin
    if (!rst) begin
      if (mem_en && (!cpu_req || cpu_stall)) dbg_acc++;
      if (mem_en && cpu_req && !cpu_stall) cpu_acc++;
      if (cpu_stall) begin
        stall_cyc++;
        last_stall_addr = mem_addr;
        check("stall_implies_req", {31'd0, cpu_req}, 32'd1);
      end
      if (dbg_ack && !ack_prev) begin
        if (exp_q.size() == 0) check("sb_unexpected_ack", 32'd1, 32'd0);
        else check("sb_dbg_rdata", dbg_rdata, exp_q.pop_front());
      end
    end
    ack_prev = dbg_ack;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation timed out");
    $fatal(1, "timeout");
  end

  initial begin
    int n, a0, c0, s0;
    rst = 1'b1;
    cpu_req = 0; cpu_we = 0; cpu_addr = 5'd0; cpu_wdata = 0;
    dbg_req = 0; dbg_we = 0; dbg_addr = 5'd0; dbg_wdata = 0;
    s_cpu_req = 0; s_dbg_req = 0;
    tick(2);
    check("rst_ack", {31'd0, dbg_ack}, 32'd0);
    check("rst_rdata", dbg_rdata, 32'd0);
    check("rst_stall_cnt", {16'd0, stall_cnt}, 32'd0);
    check("rst_stall", {31'd0, cpu_stall}, 32'd0);
    rst = 1'b0;
    tick(1);

    // 1: debug read while CPU idle
    cpu_write(5'd3, 32'hDEADBEEF);
    a0 = dbg_acc; s0 = stall_cyc;
    dbg_req = 1; dbg_we = 0; dbg_addr = 5'd3;
    exp_q.push_back(32'hDEADBEEF);
    wait_ack(20, n);
    check("t1_ack_latency", n, 2);
    check("t1_accesses", dbg_acc - a0, 1);
    check("t1_no_stall", stall_cyc - s0, 0);
    dbg_req = 0;
    tick(1);
    check("t1_ack_drop", {31'd0, dbg_ack}, 32'd0);

    // 2: CPU busy throughout, debug waits MAX_WAIT cycles then steals one
    a0 = dbg_acc; c0 = cpu_acc; s0 = stall_cyc;
    cpu_req = 1; cpu_we = 0; cpu_addr = 5'd0;
    dbg_req = 1; dbg_addr = 5'd3;
    exp_q.push_back(32'hDEADBEEF);
    wait_ack(40, n);
    check("t2_ack_latency", n, 10);
    check("t2_stall_cycles", stall_cyc - s0, 1);
    check("t2_cpu_cycles", cpu_acc - c0, 9);
    check("t2_stall_addr", {27'd0, last_stall_addr}, 32'd3);
    check("t2_stall_cnt", {16'd0, stall_cnt}, 32'd1);
    check("t2_resume_stall", {31'd0, cpu_stall}, 32'd0);
    check("t2_resume_addr", {27'd0, mem_addr}, 32'd0);
    dbg_req = 0;
    tick(1);
    cpu_req = 0;

    // 3: debug write while CPU idle, old value returned, CPU sees new value
    cpu_write(5'd7, 32'hA5A5A5A5);
    dbg_req = 1; dbg_we = 1; dbg_addr = 5'd7; dbg_wdata = 32'h12345678;
    exp_q.push_back(32'hA5A5A5A5);
    wait_ack(20, n);
    check("t3_ack_latency", n, 2);
    dbg_req = 0; dbg_we = 0;
    tick(1);
    check("t3_mem7", mem[7], 32'h12345678);
    cpu_req = 1; cpu_we = 0; cpu_addr = 5'd7;
    #1;
    check("t3_cpu_read", cpu_rdata, 32'h12345678);
    tick(1);
    cpu_req = 0;

    // 4: held request gets no second grant; re-raise starts a new one
    a0 = dbg_acc;
    dbg_req = 1; dbg_addr = 5'd7;
    exp_q.push_back(32'h12345678);
    wait_ack(20, n);
    tick(5);
    check("t4_single_access", dbg_acc - a0, 1);
    check("t4_ack_held", {31'd0, dbg_ack}, 32'd1);
    dbg_req = 0;
    tick(1);
    check("t4_ack_drop", {31'd0, dbg_ack}, 32'd0);
    dbg_req = 1; dbg_addr = 5'd3;
    exp_q.push_back(32'hDEADBEEF);
    wait_ack(20, n);
    check("t4_second_latency", n, 2);
    check("t4_two_access", dbg_acc - a0, 2);
    dbg_req = 0;
    tick(1);

    // 5: reset while a debug write waits behind a busy CPU
    a0 = dbg_acc;
    cpu_req = 1; cpu_addr = 5'd9;
    dbg_req = 1; dbg_we = 1; dbg_addr = 5'd3; dbg_wdata = 32'hBAD0BAD0;
    tick(3);
    rst = 1;
    #1;
    check("t5_ack", {31'd0, dbg_ack}, 32'd0);
    check("t5_stall", {31'd0, cpu_stall}, 32'd0);
    check("t5_mem_addr", {27'd0, mem_addr}, 32'd9);
    dbg_req = 0; dbg_we = 0;
    tick(2);
    rst = 0;
    cpu_req = 0;
    tick(3);
    check("t5_no_dbg_access", dbg_acc - a0, 0);
    check("t5_mem3_kept", mem[3], 32'hDEADBEEF);
    check("t5_stall_cnt", {16'd0, stall_cnt}, 32'd0);
    check("t5_rdata", dbg_rdata, 32'd0);

    // 6: saturation of a 2-bit stall counter, MAX_WAIT=0 grant
    s_cpu_req = 1;
    for (int t = 0; t < 4; t++) begin
      s_dbg_req = 1;
      n = 0;
      while (!s_ack && n < 10) begin
        tick(1);
        n++;
      end
      if (t == 0) check("t6_zero_wait_latency", n, 2);
      s_dbg_req = 0;
      tick(1);
      if (t == 1) check("t6_cnt_near_full", {30'd0, s_stall_cnt}, 32'd2);
    end
    check("t6_cnt_saturated", {30'd0, s_stall_cnt}, 32'd3);
    s_cpu_req = 0;

    tick(2);
    check("sb_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
